// File: rtl/clause_array_reader_pkg.sv
// Shared clause encoding constants and the read-back FSM state type.
package clause_pkg;

  localparam int VAR_W = 3;

  localparam logic [1:0] LIT_FREE = 2'd0;
  localparam logic [1:0] LIT_POS  = 2'd1;
  localparam logic [1:0] LIT_NEG  = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } reader_state_t;

endpackage

// File: rtl/clause_array_reader_if.sv
// Row-read port towards clause_array plus the valid/ready clause stream towards the bin store.
interface clause_array_reader_if #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4
);
  import clause_pkg::*;

  localparam int IDX_W = $clog2(NUM_CLAUSES);

  logic [NUM_CLAUSES-1:0]    rd_o;
  logic [WIDTH_C_LEN-1:0]    clause_len_i;
  logic [NUM_VARS*VAR_W-1:0] var_value_i;
  logic                      c_valid_o;
  logic                      c_ready_i;
  logic [IDX_W-1:0]          c_index_o;
  logic [WIDTH_C_LEN-1:0]    c_len_o;
  logic [NUM_VARS*VAR_W-1:0] c_lits_o;

  modport master (
    output rd_o, c_valid_o, c_index_o, c_len_o, c_lits_o,
    input  clause_len_i, var_value_i, c_ready_i
  );

  modport slave (
    input  rd_o, c_valid_o, c_index_o, c_len_o, c_lits_o,
    output clause_len_i, var_value_i, c_ready_i
  );

endinterface

// File: rtl/clause_array.sv
// The clause_array read-back engine is self-contained in clause_array_reader.sv.
// This file carries no module of its own.

// File: rtl/clause_array_reader.sv
// Sweeps clause_array rows with a one-hot select and emits each clause over valid/ready.
// Optional macro SKIP_EMPTY_EN: rows with zero length are skipped instead of emitted.
module clause_array_reader
  import clause_pkg::*;
#(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  clause_array_reader_if.master bus
);

  localparam int IDX_W = $clog2(NUM_CLAUSES);
  localparam int LIT_W = NUM_VARS * VAR_W;

  reader_state_t           state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        index_q;
  logic [WIDTH_C_LEN-1:0]  len_q;
  logic [LIT_W-1:0]        lits_q;
  logic                    last_row;

  assign last_row = (ptr == IDX_W'(NUM_CLAUSES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      index_q <= '0;
      len_q   <= '0;
      lits_q  <= '0;
    end else if (abort_i) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) state <= READ;
        end
        READ: begin
          state <= CAPT;
        end
        CAPT: begin
          index_q <= ptr;
          len_q   <= bus.clause_len_i;
          lits_q  <= bus.var_value_i;
`ifdef SKIP_EMPTY_EN
          // An empty row advances exactly as if its clause had been accepted.
          if (bus.clause_len_i == '0) begin
            if (last_row) begin
              state <= DONE;
            end else begin
              ptr   <= ptr + IDX_W'(1);
              state <= READ;
            end
          end else begin
            state <= SEND;
          end
`else
          state <= SEND;
`endif
        end
        SEND: begin
          if (bus.c_ready_i) begin
            if (last_row) begin
              state <= DONE;
            end else begin
              ptr   <= ptr + IDX_W'(1);
              state <= READ;
            end
          end
        end
        DONE: begin
          ptr   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state, so a reset clears them without waiting for a clock.
  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);
  assign bus.c_valid_o = (state == SEND);
  assign bus.rd_o      = (state == READ) ? (NUM_CLAUSES'(1) << ptr) : '0;
  assign bus.c_index_o = index_q;
  assign bus.c_len_o   = len_q;
  assign bus.c_lits_o  = lits_q;

endmodule

// File: tb/tb_clause_array_reader.sv
// Directed bench for clause_array_reader with a behavioural clause_array row store.
module tb_clause_array_reader;
  import clause_pkg::*;

  localparam int NC = 8;
  localparam int NV = 8;
  localparam int WL = 4;
  localparam int LW = NV * VAR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic busy_o;
  logic done_o;

  int checks = 0;
  int errors = 0;

  logic [WL-1:0] len_mem [NC];
  logic [LW-1:0] lits_mem [NC];

  clause_array_reader_if #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(WL)) bus ();

  clause_array_reader #(.NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(WL)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .abort_i (abort_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // Row store answers a one-hot select with that row's data on the following cycle.
  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (bus.rd_o[i]) begin
        bus.clause_len_i <= len_mem[i];
        bus.var_value_i  <= lits_mem[i];
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) check_output("rd_onehot0", 32'($onehot0(bus.rd_o)), 32'd1);
  end

  function automatic bit emitted(input int r);
`ifdef SKIP_EMPTY_EN
    return (len_mem[r] != '0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int next_emit(input int from);
    for (int r = from; r < NC; r++) if (emitted(r)) return r;
    return NC;
  endfunction

  task automatic load_bin1();
    len_mem  = '{4'd2, 4'd1, 4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0};
    lits_mem = '{24'h000084, 24'h000002, 24'h800428, 24'h018000,
                 24'h102000, 24'h000000, 24'h000000, 24'h000000};
  endtask

  task automatic load_bin2();
    len_mem  = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1, 4'd4};
    lits_mem = '{24'h000004, 24'h000050, 24'h010203, 24'h400000,
                 24'h0A0000, 24'h000888, 24'h204000, 24'h924924};
  endtask

  // Runs one sweep; stall holds ready low that many cycles per clause, restart_cyc pulses start mid-sweep.
  task automatic apply_stimulus(input int stall, input int restart_cyc, input string tag);
    int cyc, wait_cnt, nxt, n_xfer, exp_xfer, exp_done;
    bit finished;
    exp_done = 1;
    exp_xfer = 0;
    for (int r = 0; r < NC; r++) begin
      if (emitted(r)) begin
        exp_xfer++;
        exp_done += 3 + stall;
      end else begin
        exp_done += 2;
      end
    end
    nxt = next_emit(0);
    @(negedge clk);
    start_i = 1'b1;
    bus.c_ready_i = (stall == 0);
    @(negedge clk);
    start_i  = 1'b0;
    cyc      = 1;
    wait_cnt = 0;
    n_xfer   = 0;
    finished = 1'b0;
    while (!finished && cyc < 400) begin
      start_i = (cyc == restart_cyc);
      if (bus.c_valid_o) begin
        if (nxt >= NC) begin
          check_output({tag, "_extra_valid"}, 32'd1, 32'd0);
        end else begin
          check_output({tag, "_index"}, 32'(bus.c_index_o), 32'(nxt));
          check_output({tag, "_len"}, 32'(bus.c_len_o), 32'(len_mem[nxt]));
          check_output({tag, "_lits"}, 32'(bus.c_lits_o), 32'(lits_mem[nxt]));
        end
        if (wait_cnt < stall) begin
          bus.c_ready_i = 1'b0;
          wait_cnt++;
        end else begin
          bus.c_ready_i = 1'b1;
          wait_cnt = 0;
          n_xfer++;
          nxt = next_emit(nxt + 1);
        end
      end else begin
        bus.c_ready_i = (stall == 0);
      end
      if (done_o) begin
        check_output({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        check_output({tag, "_xfers"}, 32'(n_xfer), 32'(exp_xfer));
        check_output({tag, "_busy_in_done"}, 32'(busy_o), 32'd1);
        finished = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    if (!finished) check_output({tag, "_timeout"}, 32'd0, 32'd1);
    check_output({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    check_output({tag, "_done_after"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int guard;
    bus.c_ready_i = 1'b0;
    load_bin1();
    #12;
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_done", 32'(done_o), 32'd0);
    check_output("rst_rd", 32'(bus.rd_o), 32'd0);
    check_output("rst_valid", 32'(bus.c_valid_o), 32'd0);
    check_output("rst_index", 32'(bus.c_index_o), 32'd0);
    check_output("rst_len", 32'(bus.c_len_o), 32'd0);
    check_output("rst_lits", 32'(bus.c_lits_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] sweep bin1, ready high");
    apply_stimulus(0, -1, "bin1");

    $display("[TB] sweep bin2, ready stalled 4 cycles");
    load_bin2();
    apply_stimulus(4, -1, "bin2_stall");

    $display("[TB] abort in SEND of row 3");
    load_bin1();
    @(negedge clk);
    start_i = 1'b1;
    bus.c_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    guard = 0;
    while (!(bus.c_valid_o && bus.c_index_o == 3'd3) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_output("abort_reach_row3", 32'(guard < 40), 32'd1);
    bus.c_ready_i = 1'b0;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_output("abort_valid", 32'(bus.c_valid_o), 32'd0);
    check_output("abort_busy", 32'(busy_o), 32'd0);
    check_output("abort_done", 32'(done_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("abort_no_done", 32'(done_o), 32'd0);
    end
    apply_stimulus(0, -1, "after_abort");

    $display("[TB] reset during READ of row 2");
    load_bin2();
    @(negedge clk);
    start_i = 1'b1;
    bus.c_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    guard = 0;
    while (bus.rd_o != 8'b0000_0100 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_output("rst_reach_row2", 32'(guard < 40), 32'd1);
    rst = 1'b0;
    #1;
    check_output("midrst_rd", 32'(bus.rd_o), 32'd0);
    check_output("midrst_busy", 32'(busy_o), 32'd0);
    check_output("midrst_valid", 32'(bus.c_valid_o), 32'd0);
    check_output("midrst_index", 32'(bus.c_index_o), 32'd0);
    check_output("midrst_len", 32'(bus.c_len_o), 32'd0);
    check_output("midrst_lits", 32'(bus.c_lits_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("postrst_idle", 32'(busy_o), 32'd0);
    apply_stimulus(0, -1, "after_rst");

    $display("[TB] start pulsed while busy");
    load_bin1();
    apply_stimulus(0, 10, "start_busy");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
